inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction prefetcher. On each permit edge it issues one
// Avalon-MM burst read of BURST_LENGTH words into a first-word-fall-through
// instruction FIFO. The CPU retires the head entry with i_inst_complete, and
// i_jump redirects both fetch and PC.
// Optional feature: define FETCH_TIMEOUT_EN to abort stalled bursts after 255
// idle cycles in REQ/DATA and pulse o_fetch_error.
// Legal parameters: BURST_LENGTH 1..8; FIFO_DEPTH a power of 2, >= BURST_LENGTH.

`ifndef BURST_LENGTH
`define BURST_LENGTH 4
`endif

module inst_fetch_unit #(
  parameter int                   BURST_LENGTH = `BURST_LENGTH,
  parameter int                   FIFO_DEPTH   = 8,
  parameter int                   WORD_BITS    = 32,
  parameter logic [WORD_BITS-1:0] RESET_PC     = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_permit_fetch,
  input  logic                 i_inst_complete,
  input  logic                 i_jump,
  input  logic [WORD_BITS-1:0] i_jump_addr,
  output logic [WORD_BITS-1:0] o_inst,
  output logic                 o_inst_valid,
  output logic                 o_empty,
  output logic                 o_fetch_complete,
  output logic [WORD_BITS-1:0] o_pc,
  output logic [WORD_BITS-1:0] o_avm_address,
  output logic                 o_avm_read,
  output logic [3:0]           o_avm_burstcount,
  input  logic                 i_avm_waitrequest,
  input  logic [WORD_BITS-1:0] i_avm_readdata,
  input  logic                 i_avm_readdatavalid,
  output logic                 o_fetch_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0]           LAST_BEAT  = 4'(BURST_LENGTH - 1);
  localparam logic [CNT_W-1:0]     MAX_START  = CNT_W'(FIFO_DEPTH - BURST_LENGTH);
  localparam logic [WORD_BITS-1:0] BURST_STEP = WORD_BITS'(4 * BURST_LENGTH);
  localparam logic [WORD_BITS-1:0] WORD_MASK  = ~WORD_BITS'(3);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   permit_q;
  logic                   pending_q, pending_d;
  logic                   discard_q, discard_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;
  logic [WORD_BITS-1:0]   fetch_addr_q, fetch_addr_d;
  logic [WORD_BITS-1:0]   req_addr_q, req_addr_d;
  logic [WORD_BITS-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [WORD_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   permit_edge;
  logic                   has_space;
  logic                   push;
  logic                   pop;
  logic                   flush;
  logic                   timeout_flush;
  logic [WORD_BITS-1:0]   jump_target;

  assign permit_edge = i_permit_fetch & ~permit_q;
  assign has_space   = (count_q <= MAX_START);
  assign jump_target = i_jump_addr & WORD_MASK;
  assign flush       = i_jump | timeout_flush;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;
`endif

  // Burst FSM: start on a (possibly deferred) permit edge, request, collect beats.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d       = state_q;
    pending_d     = pending_q | permit_edge;
    discard_d     = discard_q;
    beat_cnt_d    = beat_cnt_q;
    fetch_addr_d  = fetch_addr_q;
    req_addr_d    = req_addr_q;
    push          = 1'b0;
    timeout_flush = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    timer_d       = 8'd0;
    err_d         = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pending_d && has_space) begin
          state_d    = REQ;
          pending_d  = 1'b0;
          discard_d  = 1'b0;
          beat_cnt_d = 4'd0;
          // Latch the request address so a jump cannot disturb a held request.
          req_addr_d = (i_jump ? jump_target : fetch_addr_q) & WORD_MASK;
        end
      end
      REQ: begin
        if (!i_avm_waitrequest) state_d = DATA;
      end
      DATA: begin
        if (i_avm_readdatavalid) begin
          push = !discard_q;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = 4'd0;
            if (discard_q || i_jump) begin
              state_d = IDLE;
            end else begin
              state_d      = DONE;
              fetch_addr_d = fetch_addr_q + BURST_STEP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state_q == REQ || state_q == DATA) begin
      if ((state_q == REQ && !i_avm_waitrequest) ||
          (state_q == DATA && i_avm_readdatavalid)) begin
        timer_d = 8'd0;
      end else if (timer_q == 8'hFF) begin
        state_d       = IDLE;
        beat_cnt_d    = 4'd0;
        discard_d     = 1'b0;
        err_d         = 1'b1;
        timeout_flush = 1'b1;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
`endif

    // A redirect wins over everything; beats still owed by the bus are dropped.
    if (i_jump) begin
      fetch_addr_d = jump_target;
      if (state_q == REQ || state_q == DATA) discard_d = 1'b1;
    end
    if (flush) push = 1'b0;
  end

  // FIFO pointers, occupancy and head PC.
  always_comb begin
    pop      = i_inst_complete && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (i_jump) pc_d = jump_target;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        pc_d     = pc_q + WORD_BITS'(4);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      permit_q     <= 1'b0;
      pending_q    <= 1'b0;
      discard_q    <= 1'b0;
      beat_cnt_q   <= 4'd0;
      fetch_addr_q <= RESET_PC;
      req_addr_q   <= RESET_PC & WORD_MASK;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q      <= state_d;
      permit_q     <= i_permit_fetch;
      pending_q    <= pending_d;
      discard_q    <= discard_d;
      beat_cnt_q   <= beat_cnt_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Instruction storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; pointers and count define validity.
    if (push && !rst) mem_q[wr_ptr_q] <= i_avm_readdata;
  end

`ifdef FETCH_TIMEOUT_EN
  // Stall watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
  assign o_fetch_error = err_q;
`else
  assign o_fetch_error = 1'b0;
`endif

  assign o_empty          = (count_q == '0);
  assign o_inst_valid     = !o_empty;
  assign o_inst           = mem_q[rd_ptr_q];
  assign o_pc             = pc_q;
  assign o_avm_address    = req_addr_q;
  assign o_avm_read       = (state_q == REQ);
  assign o_avm_burstcount = 4'(BURST_LENGTH);
  assign o_fetch_complete = (state_q == DONE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: a bench-side bus model drives bursts; the
// words that should enter the FIFO are queued and compared as they retire.
module tb_inst_fetch_unit;
  localparam int BL = 4;
  localparam int W  = 32;
  localparam int JUMP_IN_REQ = 99;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_permit_fetch, i_inst_complete, i_jump;
  logic [W-1:0] i_jump_addr;
  logic [W-1:0] o_inst, o_pc, o_avm_address;
  logic         o_inst_valid, o_empty, o_fetch_complete, o_avm_read, o_fetch_error;
  logic [3:0]   o_avm_burstcount;
  logic         i_avm_waitrequest, i_avm_readdatavalid;
  logic [W-1:0] i_avm_readdata;

  always #5 clk = ~clk;

  inst_fetch_unit #(.BURST_LENGTH(BL), .FIFO_DEPTH(8), .WORD_BITS(W), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .i_permit_fetch(i_permit_fetch), .i_inst_complete(i_inst_complete),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr),
    .o_inst(o_inst), .o_inst_valid(o_inst_valid), .o_empty(o_empty),
    .o_fetch_complete(o_fetch_complete), .o_pc(o_pc),
    .o_avm_address(o_avm_address), .o_avm_read(o_avm_read),
    .o_avm_burstcount(o_avm_burstcount), .i_avm_waitrequest(i_avm_waitrequest),
    .i_avm_readdata(i_avm_readdata), .i_avm_readdatavalid(i_avm_readdatavalid),
    .o_fetch_error(o_fetch_error)
  );

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_pc = '0;
  logic [W-1:0] exp_fetch_addr = '0;
  int           permit_left = 0;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: advance past the edge, then release the permit window when due.
  task automatic step();
    @(posedge clk);
    #1;
    if (permit_left > 0) begin
      permit_left--;
      if (permit_left == 0) i_permit_fetch = 1'b0;
    end
  endtask

  task automatic start_permit();
    i_permit_fetch = 1'b1;
    permit_left    = BL;
  endtask

  task automatic wait_read(output int n);
    n = 0;
    while (!o_avm_read && n < 40) begin
      step();
      n++;
    end
    check("req_seen", 32'(o_avm_read), 32'd1);
  endtask

  task automatic run_burst(input bit do_permit, input int waits, input int jump_at,
                           input logic [W-1:0] jaddr, input logic [W-1:0] d0,
                           input logic [W-1:0] dstep);
    bit           dropped = 1'b0;
    int           n;
    logic [W-1:0] req_addr;
    logic [W-1:0] d;
    i_avm_waitrequest = (waits > 0);
    if (do_permit) start_permit();
    wait_read(n);
    if (do_permit) check("req_latency", 32'(n), 32'd1);
    req_addr = exp_fetch_addr;
    check("avm_addr", o_avm_address, req_addr);
    check("avm_burstcount", 32'(o_avm_burstcount), 32'(BL));
    for (int i = 0; i < waits; i++) begin
      check("wait_read_held", 32'(o_avm_read), 32'd1);
      check("wait_addr_held", o_avm_address, req_addr);
      if (i == 0 && jump_at == JUMP_IN_REQ) begin
        i_jump = 1'b1; i_jump_addr = jaddr;
        dropped = 1'b1;
        exp_q.delete();
        exp_pc = jaddr & ~32'd3;
        exp_fetch_addr = exp_pc;
      end
      step();
      i_jump = 1'b0;
    end
    i_avm_waitrequest = 1'b0;
    step();
    check("read_released", 32'(o_avm_read), 32'd0);
    for (int k = 0; k < BL; k++) begin
      d = d0 + 32'(k) * dstep;
      i_avm_readdatavalid = 1'b1;
      i_avm_readdata      = d;
      if (k == jump_at) begin
        i_jump = 1'b1; i_jump_addr = jaddr;
        dropped = 1'b1;
        exp_q.delete();
        exp_pc = jaddr & ~32'd3;
        exp_fetch_addr = exp_pc;
      end else if (!dropped) begin
        exp_q.push_back(d);
      end
      step();
      i_jump = 1'b0;
    end
    i_avm_readdatavalid = 1'b0;
    check("fetch_complete", 32'(o_fetch_complete), dropped ? 32'd0 : 32'd1);
    if (!dropped) exp_fetch_addr += 32'(4 * BL);
    step();
    check("fetch_complete_end", 32'(o_fetch_complete), 32'd0);
    check("empty_after_burst", 32'(o_empty), (exp_q.size() == 0) ? 32'd1 : 32'd0);
    if (exp_q.size() > 0) check("head_after_burst", o_inst, exp_q[0]);
  endtask

  task automatic pop_one();
    if (exp_q.size() > 0) begin
      check("inst_valid", 32'(o_inst_valid), 32'd1);
      check("inst", o_inst, exp_q[0]);
      check("pc", o_pc, exp_pc);
    end else begin
      check("empty", 32'(o_empty), 32'd1);
    end
    i_inst_complete = 1'b1;
    step();
    i_inst_complete = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_pc += 32'd4;
    end
    check("pc_after_pop", o_pc, exp_pc);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    i_permit_fetch = 1'b0; i_inst_complete = 1'b0; i_jump = 1'b0; i_jump_addr = '0;
    i_avm_waitrequest = 1'b0; i_avm_readdata = '0; i_avm_readdatavalid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state.
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_valid", 32'(o_inst_valid), 32'd0);
    check("rst_read", 32'(o_avm_read), 32'd0);
    check("rst_complete", 32'(o_fetch_complete), 32'd0);
    check("rst_error", 32'(o_fetch_error), 32'd0);
    check("rst_pc", o_pc, 32'd0);

    // First burst 0x11..0x44 at address 0, then retire all plus one extra.
    run_burst(1'b1, 0, -1, '0, 32'h11, 32'h11);
    check("first_head", o_inst, 32'h11);
    for (int i = 0; i < 5; i++) pop_one();
    check("pc_after_drain", o_pc, 32'd16);
    check("empty_after_drain", 32'(o_empty), 32'd1);

    // Jump to 0x103 during the second beat: rest dropped, redirect to 0x100.
    run_burst(1'b1, 0, 1, 32'h103, 32'hA0, 32'd1);
    check("jump_empty", 32'(o_empty), 32'd1);
    check("jump_pc", o_pc, 32'h100);

    // Waitrequest held 3 cycles, then a second burst to reach 8 entries.
    run_burst(1'b1, 3, -1, '0, 32'hB000_0000, 32'd4);
    run_burst(1'b1, 0, -1, '0, $urandom, 32'h0101_0101);

    // Two pops leave 6/8: a permit must wait until two more pops free space.
    pop_one(); pop_one();
    start_permit();
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_space_read", 32'(o_avm_read), 32'd0);
    end
    pop_one();
    check("one_pop_read", 32'(o_avm_read), 32'd0);
    pop_one();
    run_burst(1'b0, 0, -1, '0, 32'hC0DE_0000, 32'd3);
    while (exp_q.size() > 0) pop_one();
    pop_one();

    // Jump while the request is still held: every beat must be discarded.
    run_burst(1'b1, 2, JUMP_IN_REQ, 32'h202, 32'hD0, 32'd1);
    check("req_jump_empty", 32'(o_empty), 32'd1);
    check("req_jump_pc", o_pc, 32'h200);

    // Reset in the middle of a burst; late beats must be ignored.
    i_avm_waitrequest = 1'b0;
    start_permit();
    wait_read(n);
    step();
    for (int k = 0; k < BL; k++) begin
      i_avm_readdatavalid = 1'b1;
      i_avm_readdata      = 32'hE0 + 32'(k);
      if (k == 2) begin
        i_permit_fetch = 1'b0; permit_left = 0;
        rst = 1'b1;
      end
      step();
      rst = 1'b0;
    end
    i_avm_readdatavalid = 1'b0;
    exp_q.delete(); exp_pc = '0; exp_fetch_addr = '0;
    check("midrst_empty", 32'(o_empty), 32'd1);
    check("midrst_read", 32'(o_avm_read), 32'd0);
    check("midrst_pc", o_pc, 32'd0);
    step();
    check("midrst_complete", 32'(o_fetch_complete), 32'd0);

    // Normal operation resumes from RESET_PC.
    run_burst(1'b1, 1, -1, '0, 32'hF00D_0000, 32'd1);
    while (exp_q.size() > 0) pop_one();

`ifdef FETCH_TIMEOUT_EN
    // No beats after an accepted request: watchdog fires and returns to IDLE.
    i_avm_waitrequest = 1'b0;
    start_permit();
    wait_read(n);
    step();
    n = 0;
    while (!o_fetch_error && n < 400) begin
      step();
      n++;
    end
    check("timeout_seen", 32'(o_fetch_error), 32'd1);
    check("timeout_window", 32'((n >= 250) && (n <= 260)), 32'd1);
    step();
    check("timeout_pulse_end", 32'(o_fetch_error), 32'd0);
    check("timeout_idle_read", 32'(o_avm_read), 32'd0);
    check("timeout_empty", 32'(o_empty), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
